// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter: FSM states, grant encoding and
// the latched request record driven onto the memory port.
package MemArbStruct;

    localparam int ARB_ADDR_W = 64;
    localparam int ARB_DATA_W = 64;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        GRANT_NONE,
        GRANT_I,
        GRANT_D
    } grant_t;

    // Fields are sized for the widest supported configuration; the top
    // module uses the low ADDR_WIDTH / DATA_WIDTH bits.
    typedef struct packed {
        logic [ARB_ADDR_W-1:0]   addr;
        logic [ARB_DATA_W-1:0]   wdata;
        logic [ARB_DATA_W/8-1:0] wmask;
        logic                    we;
    } req_t;

endpackage

// File: rtl/mem_port_arbiter_grant_select.sv
// Winner selection between instruction fetch and data/PTW requests.
// Optional feature: MEM_ARB_ROUND_ROBIN_EN selects round-robin on conflict;
// otherwise the data port always wins.
module arb_grant_select
    import MemArbStruct::*;
(
    input  logic   i_req,
    input  logic   d_req,
    input  grant_t last_grant,
    output grant_t grant
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // On conflict, serve the port that was not granted last time.
    always_comb begin
        grant = GRANT_NONE;
        if (i_req && d_req) begin
            grant = (last_grant == GRANT_D) ? GRANT_I : GRANT_D;
        end else if (d_req) begin
            grant = GRANT_D;
        end else if (i_req) begin
            grant = GRANT_I;
        end
    end
`else
    // History is tracked by the caller but has no effect in fixed priority.
    logic unused_last_grant;
    assign unused_last_grant = ^last_grant;

    // Data port has fixed priority over instruction fetch.
    always_comb begin
        grant = GRANT_NONE;
        if (d_req) begin
            grant = GRANT_D;
        end else if (i_req) begin
            grant = GRANT_I;
        end
    end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction fetch and data/PTW requests onto one memory port.
// One transaction at a time: IDLE latches the winner, BUSY holds mem_req
// until mem_ready, DONE releases the winner's stall for a single cycle.
// Optional feature: MEM_ARB_ROUND_ROBIN_EN (resolved in arb_grant_select).
module mem_port_arbiter
    import MemArbStruct::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    i_req,
    input  logic [ADDR_WIDTH-1:0]   i_addr,
    output logic                    i_stall,
    output logic [31:0]             i_inst,
    input  logic                    d_wen,
    input  logic                    d_ren,
    input  logic [ADDR_WIDTH-1:0]   d_addr,
    input  logic [DATA_WIDTH-1:0]   d_wdata,
    input  logic [DATA_WIDTH/8-1:0] d_wmask,
    output logic                    d_stall,
    output logic [DATA_WIDTH-1:0]   d_rdata,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wmask,
    input  logic                    mem_ready,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);

    state_t                state_q, state_d;
    grant_t                grant_q, grant_d;
    grant_t                last_q, last_d;
    grant_t                sel_grant;
    req_t                  req_q, req_d;
    logic [DATA_WIDTH-1:0] buf_q, buf_d;
    logic                  d_req;

    assign d_req = d_wen | d_ren;

    arb_grant_select u_sel (
        .i_req      (i_req),
        .d_req      (d_req),
        .last_grant (last_q),
        .grant      (sel_grant)
    );

    // State, grant history, latched request and response buffer.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            grant_q <= GRANT_NONE;
            last_q  <= GRANT_I;
            req_q   <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            req_q   <= req_d;
            buf_q   <= buf_d;
        end
    end

    // Next-state logic: grant in IDLE, wait for mem_ready in BUSY, one DONE cycle.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        req_d   = req_q;
        buf_d   = buf_q;
        case (state_q)
            IDLE: begin
                if (sel_grant != GRANT_NONE) begin
                    grant_d = sel_grant;
                    last_d  = sel_grant;
                    req_d   = '0;
                    if (sel_grant == GRANT_D) begin
                        req_d.addr[ADDR_WIDTH-1:0]    = d_addr;
                        req_d.wdata[DATA_WIDTH-1:0]   = d_wdata;
                        req_d.wmask[DATA_WIDTH/8-1:0] = d_wmask;
                        req_d.we                      = d_wen;
                    end else begin
                        req_d.addr[ADDR_WIDTH-1:0] = i_addr;
                    end
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // The transaction completes even if the requester has gone away.
                if (mem_ready) begin
                    buf_d   = mem_rdata;
                    state_d = DONE;
                end
            end
            DONE: begin
                grant_d = GRANT_NONE;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Memory port and response outputs.
    always_comb begin
        mem_req   = (state_q == BUSY);
        mem_we    = req_q.we;
        mem_addr  = req_q.addr[ADDR_WIDTH-1:0];
        mem_wdata = req_q.wdata[DATA_WIDTH-1:0];
        mem_wmask = req_q.wmask[DATA_WIDTH/8-1:0];
        d_rdata   = buf_q;
        i_inst    = req_q.addr[2] ? buf_q[63:32] : buf_q[31:0];
        i_stall   = i_req & ~((state_q == DONE) && (grant_q == GRANT_I));
        d_stall   = d_req & ~((state_q == DONE) && (grant_q == GRANT_D));
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; expectations follow the build's
// MEM_ARB_ROUND_ROBIN_EN setting.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rstn;
    logic        i_req;
    logic [63:0] i_addr;
    logic        i_stall;
    logic [31:0] i_inst;
    logic        d_wen, d_ren;
    logic [63:0] d_addr, d_wdata;
    logic [7:0]  d_wmask;
    logic        d_stall;
    logic [63:0] d_rdata;
    logic        mem_req, mem_we;
    logic [63:0] mem_addr, mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_ready;
    logic [63:0] mem_rdata;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_stall   (i_stall),
        .i_inst    (i_inst),
        .d_wen     (d_wen),
        .d_ren     (d_ren),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_wmask   (d_wmask),
        .d_stall   (d_stall),
        .d_rdata   (d_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wmask (mem_wmask),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [63:0] exp_addr2;
    logic        exp_istall2, exp_dstall2;

    initial begin
        rstn = 1'b0; i_req = 1'b1; i_addr = '0;
        d_wen = 1'b0; d_ren = 1'b0; d_addr = '0; d_wdata = '0; d_wmask = '0;
        mem_ready = 1'b0; mem_rdata = '0;

        // Reset values; stalls follow requests combinationally.
        @(negedge clk);
        check("rst_i_stall", i_stall, 1);
        check("rst_d_stall", d_stall, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_mem_wmask", mem_wmask, 0);
        check("rst_d_rdata", d_rdata, 0);
        check("rst_i_inst", i_inst, 0);
        d_ren = 1'b1;
        #1 check("rst_d_stall_req", d_stall, 1);
        d_ren = 1'b0; i_req = 1'b0;
        tick();
        rstn = 1'b1;

        // Minimum-latency fetch, upper word selected by addr[2].
        i_req = 1'b1; i_addr = 64'h8000_0004;
        @(negedge clk);
        check("f_idle_stall", i_stall, 1);
        check("f_idle_req", mem_req, 0);
        tick();
        mem_ready = 1'b1; mem_rdata = 64'h1111_2222_3333_4444;
        @(negedge clk);
        check("f_busy_req", mem_req, 1);
        check("f_busy_addr", mem_addr, 64'h8000_0004);
        check("f_busy_we", mem_we, 0);
        check("f_busy_stall", i_stall, 1);
        tick();
        mem_ready = 1'b0; mem_rdata = '0;
        @(negedge clk);
        check("f_done_stall", i_stall, 0);
        check("f_done_inst", i_inst, 32'h1111_2222);
        check("f_done_req", mem_req, 0);
        check("f_done_rdata", d_rdata, 64'h1111_2222_3333_4444);
        tick();
        i_req = 1'b0;

        // Write + read together is a write.
        d_wen = 1'b1; d_ren = 1'b1; d_addr = 64'h8000_1000; d_wdata = 64'hDEAD; d_wmask = 8'hFF;
        @(negedge clk);
        check("w_idle_stall", d_stall, 1);
        tick();
        @(negedge clk);
        check("w_busy_req", mem_req, 1);
        check("w_busy_we", mem_we, 1);
        check("w_busy_addr", mem_addr, 64'h8000_1000);
        check("w_busy_wdata", mem_wdata, 64'hDEAD);
        check("w_busy_wmask", mem_wmask, 8'hFF);
        check("w_busy_stall", d_stall, 1);
        tick();
        mem_ready = 1'b1; mem_rdata = 64'h0123_4567_89AB_CDEF;
        @(negedge clk);
        check("w_ready_stall", d_stall, 1);
        tick();
        mem_ready = 1'b0;
        @(negedge clk);
        check("w_done_stall", d_stall, 0);
        check("w_done_rdata", d_rdata, 64'h0123_4567_89AB_CDEF);
        tick();
        d_wen = 1'b0; d_ren = 1'b0;

        // Slow memory: request held stable across five wait cycles.
        i_req = 1'b1; i_addr = 64'h8000_2000;
        tick();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("slow_req", mem_req, 1);
            check("slow_addr", mem_addr, 64'h8000_2000);
            check("slow_stall", i_stall, 1);
            tick();
        end
        mem_ready = 1'b1; mem_rdata = 64'hAAAA_BBBB_CCCC_DDDD;
        @(negedge clk);
        check("slow_last_stall", i_stall, 1);
        tick();
        mem_ready = 1'b0;
        @(negedge clk);
        check("slow_done_stall", i_stall, 0);
        check("slow_done_inst", i_inst, 32'hCCCC_DDDD);
        tick();
        i_req = 1'b0;

        // Two back-to-back conflicts; last grant was I, so the first goes to D.
`ifdef MEM_ARB_ROUND_ROBIN_EN
        exp_addr2 = 64'h8000_3004; exp_istall2 = 1'b0; exp_dstall2 = 1'b1;
`else
        exp_addr2 = 64'h8000_4000; exp_istall2 = 1'b1; exp_dstall2 = 1'b0;
`endif
        i_req = 1'b1; i_addr = 64'h8000_3004; d_ren = 1'b1; d_addr = 64'h8000_4000;
        d_wdata = '0; d_wmask = '0;
        tick();
        @(negedge clk);
        check("c1_addr", mem_addr, 64'h8000_4000);
        check("c1_we", mem_we, 0);
        mem_ready = 1'b1; mem_rdata = 64'h5555_6666_7777_8888;
        tick();
        mem_ready = 1'b0;
        @(negedge clk);
        check("c1_d_stall", d_stall, 0);
        check("c1_i_stall", i_stall, 1);
        tick();
        @(negedge clk);
        check("c_idle_req", mem_req, 0);
        tick();
        @(negedge clk);
        check("c2_addr", mem_addr, exp_addr2);
        mem_ready = 1'b1; mem_rdata = 64'h9999_8888_7777_6666;
        tick();
        mem_ready = 1'b0;
        @(negedge clk);
        check("c2_i_stall", i_stall, exp_istall2);
        check("c2_d_stall", d_stall, exp_dstall2);
        check("c2_rdata", d_rdata, 64'h9999_8888_7777_6666);
        tick();
        i_req = 1'b0; d_ren = 1'b0;

        // Reset in the middle of BUSY, then a stray mem_ready in IDLE.
        i_req = 1'b1; i_addr = 64'h8000_5000;
        tick();
        @(negedge clk);
        check("r_busy_req", mem_req, 1);
        #2 rstn = 1'b0; i_req = 1'b0;
        #1;
        check("r_async_req", mem_req, 0);
        check("r_async_addr", mem_addr, 0);
        check("r_async_rdata", d_rdata, 0);
        check("r_async_inst", i_inst, 0);
        tick();
        rstn = 1'b1; mem_ready = 1'b1; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        check("r_idle_req", mem_req, 0);
        tick();
        mem_ready = 1'b0; d_ren = 1'b1;
        @(negedge clk);
        check("r_post_rdata", d_rdata, 0);
        check("r_post_inst", i_inst, 0);
        check("r_post_addr", mem_addr, 0);
        check("r_post_d_stall", d_stall, 1);
        check("r_post_i_stall", i_stall, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
